// File: rtl/prog_mem_responder_pkg.sv
// Shared types and constants for the program-memory responder.
// State encoding, word width and default geometry live here.
package prog_mem_responder_pkg;

  localparam int unsigned WORD_W           = 16;
  localparam int unsigned DEFAULT_DEPTH    = 1024;
  localparam int unsigned DEFAULT_DATA_LAT = 2;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Full-width compare; high address bits never alias onto low words.
  function automatic logic addr_in_range(input logic [15:0] addr,
                                         input int unsigned depth);
    return {16'b0, addr} < depth;
  endfunction

endpackage

// File: rtl/prog_mem_responder_mem_array.sv
// DEPTH x 16 storage: one synchronous write port, two synchronous read ports.
// Read-during-write on the same address returns the old word.
module mem_array
  import prog_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [WORD_W-1:0] rdata_b
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto block RAM and keeps its image
  // across a CPU reset; the callers mask the read data instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/prog_mem_responder.sv
// Program memory with boot-loader write port, 1-cycle fetch port and a
// DATA_LAT-cycle data port (DATA_LAT >= 2: address stage, RAM stage, delays).
module prog_mem_responder
  import prog_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned DATA_LAT = DEFAULT_DATA_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       i_addr,
  output logic [WORD_W-1:0] i_data,
  input  logic [15:0]       d_addr,
  output logic [WORD_W-1:0] d_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [15:0]       ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ready,
  output logic              err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic              i_ok_q, i_ok_d;
  logic [AW-1:0]     d_addr_q, d_addr_d;
  logic              d_ok_q, d_ok_d;
  logic              d_ok2_q, d_ok2_d;
  logic [WORD_W-1:0] i_rd, d_rd, d_stage;
  logic              i_in, d_in, ld_in, ld_fire, mem_we;

  assign i_in    = addr_in_range(i_addr, DEPTH);
  assign d_in    = addr_in_range(d_addr, DEPTH);
  assign ld_in   = addr_in_range(ld_addr, DEPTH);
  assign ld_fire = (state_q == BOOT) && ld_valid;
  // A write coinciding with reset must not land in the array.
  assign mem_we  = ld_fire && ld_in && rst_n;

  assign ld_ready = (state_q == BOOT);
  assign ready    = (state_q == RUN);
  assign err      = err_q;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    i_ok_d   = 1'b0;
    d_ok_d   = 1'b0;
    d_ok2_d  = d_ok_q;
    d_addr_d = d_addr[AW-1:0];
    if (state_q == BOOT) begin
      if (ld_fire) begin
        if (!ld_in)  err_d   = 1'b1;
        if (ld_last) state_d = RUN;
      end
    end else begin
      i_ok_d = i_in;
      d_ok_d = d_in;
      if (!i_in || !d_in) err_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      err_q    <= 1'b0;
      i_ok_q   <= 1'b0;
      d_addr_q <= '0;
      d_ok_q   <= 1'b0;
      d_ok2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      i_ok_q   <= i_ok_d;
      d_addr_q <= d_addr_d;
      d_ok_q   <= d_ok_d;
      d_ok2_q  <= d_ok2_d;
    end
  end

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (ld_addr[AW-1:0]),
    .wdata   (ld_data),
    .raddr_a (i_addr[AW-1:0]),
    .rdata_a (i_rd),
    .raddr_b (d_addr_q),
    .rdata_b (d_rd)
  );

  // Valid flags reset asynchronously, so masked outputs clear immediately.
  assign i_data  = i_ok_q  ? i_rd : '0;
  assign d_stage = d_ok2_q ? d_rd : '0;

  if (DATA_LAT > 2) begin : g_dly
    localparam int unsigned N = DATA_LAT - 2;
    logic [WORD_W-1:0] dly_q [N];
    logic [WORD_W-1:0] dly_d [N];

    always_comb begin
      dly_d[0] = d_stage;
      for (int k = 1; k < int'(N); k++) dly_d[k] = dly_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < int'(N); k++) dly_q[k] <= '0;
      end else begin
        for (int k = 0; k < int'(N); k++) dly_q[k] <= dly_d[k];
      end
    end

    assign d_data = dly_q[N-1];
  end else begin : g_nodly
    assign d_data = d_stage;
  end

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed bench for prog_mem_responder: boot load, both read ports,
// out-of-range handling, reset mid-RUN with memory retention.
module tb_prog_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_addr, i_data, d_addr, d_data;
  logic        ld_valid, ld_ready, ld_last, ready, err;
  logic [15:0] ld_addr, ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prog_mem_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .d_addr   (d_addr),
    .d_data   (d_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ready    (ready),
    .err      (err)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] dat, input logic last);
    ld_valid = 1'b1; ld_addr = a; ld_data = dat; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_addr = '0; d_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    #3;
    check("rst_ready", 16'(ready), 16'd0);
    check("rst_ld_ready", 16'(ld_ready), 16'd1);
    check("rst_i_data", i_data, 16'h0000);
    check("rst_d_data", d_data, 16'h0000);
    check("rst_err", 16'(err), 16'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // BOOT: reads return zero
    step();
    check("boot_i_data", i_data, 16'h0000);
    check("boot_d_data", d_data, 16'h0000);

    load(16'd0, 16'h1005, 1'b0);
    check("boot_still", 16'(ready), 16'd0);
    load(16'd1, 16'h3000, 1'b1);
    check("run_ready", 16'(ready), 16'd1);
    check("run_ld_ready", 16'(ld_ready), 16'd0);
    check("run_err0", 16'(err), 16'd0);

    // Fetch and data ports
    i_addr = 16'd0; d_addr = 16'd1; step();
    check("i_addr0", i_data, 16'h1005);
    i_addr = 16'd1; d_addr = 16'd0; step();
    check("i_addr1", i_data, 16'h3000);
    check("d_addr1_lat2", d_data, 16'h3000);
    i_addr = 16'd1; d_addr = 16'd1; step();
    check("i_same", i_data, 16'h3000);
    check("d_addr0_lat2", d_data, 16'h1005);
    i_addr = 16'd0; step();
    check("d_same", d_data, 16'h3000);

    // Data read out of range while an in-range read is in flight
    d_addr = 16'd1024; step();
    check("oor_err_set", 16'(err), 16'd1);
    check("inflight_ok", d_data, 16'h3000);
    d_addr = 16'd0; step();
    check("oor_d_zero", d_data, 16'h0000);
    d_addr = 16'd1; step();
    check("after_oor_d0", d_data, 16'h1005);
    i_addr = 16'h8001; step();
    check("after_oor_d1", d_data, 16'h3000);
    check("i_noalias", i_data, 16'h0000);
    check("err_held", 16'(err), 16'd1);
    i_addr = 16'd0; d_addr = 16'd0;

    // Reset in RUN; a write attempted under reset is dropped
    rst_n = 1'b0; #1;
    check("rst2_ready", 16'(ready), 16'd0);
    check("rst2_ld_ready", 16'(ld_ready), 16'd1);
    check("rst2_i_data", i_data, 16'h0000);
    check("rst2_d_data", d_data, 16'h0000);
    check("rst2_err", 16'(err), 16'd0);
    ld_valid = 1'b1; ld_addr = 16'd0; ld_data = 16'hBEEF; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0; rst_n = 1'b1;
    check("rst2_boot", 16'(ready), 16'd0);

    // Out-of-range loader write with ld_last
    load(16'd2000, 16'h5555, 1'b1);
    check("ld_oor_err", 16'(err), 16'd1);
    check("ld_oor_run", 16'(ready), 16'd1);
    i_addr = 16'd0; step();
    check("retain_mem0", i_data, 16'h1005);
    i_addr = 16'd1; step();
    check("retain_mem1", i_data, 16'h3000);

    // Reload only the last word, then confirm RUN ignores the loader
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();
    load(16'd5, 16'h0ABC, 1'b1);
    check("reload_ready", 16'(ready), 16'd1);
    check("reload_err0", 16'(err), 16'd0);
    ld_valid = 1'b1; ld_addr = 16'd1; ld_data = 16'hDEAD;
    i_addr = 16'd0; d_addr = 16'd5; step();
    check("reload_mem0", i_data, 16'h1005);
    ld_addr = 16'd3000;
    i_addr = 16'd5; d_addr = 16'd1; step();
    check("reload_mem5", i_data, 16'h0ABC);
    check("reload_d5", d_data, 16'h0ABC);
    ld_valid = 1'b0; step();
    check("run_no_write", d_data, 16'h3000);
    check("run_ld_no_err", 16'(err), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
